// File: rtl/switch_pkg.sv
// Shared constants, FSM state encoding and one-hot/binary helpers for the switch scheduler.
// The helpers are sized by the package defaults, so the top must be built with matching N/AW.
package switch_pkg;

    localparam int N_DEF  = 4;
    localparam int DW_DEF = 4;
    localparam int AW_DEF = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_GRANT = 2'd1;
    localparam state_t ST_WRITE = 2'd2;

    function automatic logic [N_DEF-1:0] bin_to_onehot(input logic [AW_DEF-1:0] b);
        logic [N_DEF-1:0] oh;
        oh    = '0;
        oh[b] = 1'b1;
        return oh;
    endfunction

    function automatic logic [AW_DEF-1:0] onehot_to_bin(input logic [N_DEF-1:0] oh);
        logic [AW_DEF-1:0] b;
        b = '0;
        for (int i = 0; i < N_DEF; i++) begin
            if (oh[i]) begin
                b = b | AW_DEF'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/switch_sched_rr_pick.sv
// Combinational round-robin picker: first eligible port at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int AW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [AW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    logic [AW-1:0] idx;

    // AW-bit addition wraps naturally because N == 2**AW
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr + AW'(i);
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_sched.sv
// Crossbar transfer scheduler: round-robin grant of one port at a time, then a buffered
// write into the destination FIFO, stalling while that FIFO is full.
module switch_sched
    import switch_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]    rqt,
    input  logic [N*AW-1:0] adr_i,
    input  logic [N*DW-1:0] dat_i,
    input  logic [N-1:0]    full_i,
    output logic [N-1:0]    gnt,
    output logic [DW-1:0]   dat_o,
    output logic [N-1:0]    wen,
    output logic            busy,
    output logic [7:0]      xfer_cnt
);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] dat_buf;
    logic [AW-1:0] adr_buf;

    logic [N-1:0]  eligible;
    logic [N-1:0]  pick;
    logic          pick_valid;
    logic [AW-1:0] win_bin;
    logic [DW-1:0] sel_dat;
    logic [AW-1:0] sel_adr;
    logic          dest_ready;

    // A request only competes if its destination FIFO can currently accept data
    always_comb begin
        eligible = '0;
        for (int k = 0; k < N; k++) begin
            eligible[k] = rqt[k] & ~full_i[adr_i[k*AW +: AW]];
        end
    end

    rr_pick #(.N(N), .AW(AW)) u_pick (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (pick),
        .valid    (pick_valid)
    );

    always_comb begin
        sel_dat = '0;
        sel_adr = '0;
        for (int k = 0; k < N; k++) begin
            if (pick[k]) begin
                sel_dat = dat_i[k*DW +: DW];
                sel_adr = adr_i[k*AW +: AW];
            end
        end
    end

    assign win_bin    = onehot_to_bin(pick);
    assign dest_ready = ~full_i[adr_buf];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt      <= '0;
            dat_buf  <= '0;
            adr_buf  <= '0;
            xfer_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt     <= pick;
                        dat_buf <= sel_dat;
                        adr_buf <= sel_adr;
                        ptr     <= win_bin + AW'(1);
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    gnt   <= '0;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (dest_ready) begin
                        xfer_cnt <= xfer_cnt + 8'd1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write enable follows full_i combinationally so a FIFO freeing up is used in the same cycle
    assign wen   = (state == ST_WRITE && dest_ready) ? bin_to_onehot(adr_buf) : '0;
    assign dat_o = dat_buf;
    assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_switch_sched.sv
// Randomised and directed bench for switch_sched with a transaction-level reference model
// feeding grant/write scoreboards that a negedge monitor drains.
module tb_switch_sched;

    localparam int N = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  rqt;
    logic [7:0]  adr;
    logic [15:0] dat;
    logic [3:0]  full;
    logic [3:0]  gnt;
    logic [3:0]  dat_o;
    logic [3:0]  wen;
    logic        busy;
    logic [7:0]  xfer_cnt;

    typedef struct {
        int port;
        int cyc;
    } gnt_exp_t;

    typedef struct {
        int dest;
        int data;
        int cnt;
        int cyc;
    } wr_exp_t;

    gnt_exp_t gnt_q[$];
    wr_exp_t  wr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: one transfer in flight, described by its phase and destination
    int m_ptr, m_cnt, m_done, m_dest, m_data, m_last_grant;
    bit m_active, m_writing;

    gnt_exp_t g_pop;
    wr_exp_t  w_pop;

    logic [3:0] r_rqt;
    logic [1:0] r_adr [4];
    logic [3:0] r_dat [4];
    logic [3:0] r_full;

    switch_sched #(.N(4), .DW(4), .AW(2)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .rqt      (rqt),
        .adr_i    (adr),
        .dat_i    (dat),
        .full_i   (full),
        .gnt      (gnt),
        .dat_o    (dat_o),
        .wen      (wen),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int adr_of(int k);
        return int'(adr[k*2 +: 2]);
    endfunction

    function automatic int dat_of(int k);
        return int'(dat[k*4 +: 4]);
    endfunction

    // Decide what the coming rising edge does, from the inputs the DUT will sample there
    task automatic model_edge();
        bit found;
        m_last_grant = -1;
        if (!m_active) begin
            found = 1'b0;
            for (int j = 0; j < N; j++) begin
                int k;
                k = (m_ptr + j) % N;
                if (!found && rqt[k] && !full[adr_of(k)]) begin
                    found        = 1'b1;
                    m_dest       = adr_of(k);
                    m_data       = dat_of(k);
                    m_ptr        = (k + 1) % N;
                    m_active     = 1'b1;
                    m_writing    = 1'b0;
                    m_last_grant = k;
                    gnt_q.push_back('{port: k, cyc: cyc + 1});
                end
            end
        end else if (!m_writing) begin
            m_writing = 1'b1;
        end else if (!full[m_dest]) begin
            wr_q.push_back('{dest: m_dest, data: m_data, cnt: m_cnt, cyc: cyc});
            m_active = 1'b0;
            m_cnt    = (m_cnt + 1) % 256;
            m_done++;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] rq, input logic [7:0] ad,
                                 input logic [15:0] dt, input logic [3:0] fl);
        rqt  = rq;
        adr  = ad;
        dat  = dt;
        full = fl;
        model_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 0);
        checkOutput("rst_wen", 32'(wen), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_cnt", 32'(xfer_cnt), 0);
        checkOutput("rst_dat", 32'(dat_o), 0);
        gnt_q.delete();
        wr_q.delete();
        m_ptr     = 0;
        m_cnt     = 0;
        m_done    = 0;
        m_active  = 1'b0;
        m_writing = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every grant or write the DUT shows must match the next expected transaction
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != 4'd0) begin
                if (gnt_q.size() == 0) begin
                    checkOutput("spurious_gnt", 32'(gnt), 0);
                end else begin
                    g_pop = gnt_q.pop_front();
                    checkOutput("gnt_port", 32'(gnt), 32'd1 << g_pop.port);
                    checkOutput("gnt_cycle", cyc, g_pop.cyc);
                end
            end
            if (wen != 4'd0) begin
                if (wr_q.size() == 0) begin
                    checkOutput("spurious_wen", 32'(wen), 0);
                end else begin
                    w_pop = wr_q.pop_front();
                    checkOutput("wen_dest", 32'(wen), 32'd1 << w_pop.dest);
                    checkOutput("wen_data", 32'(dat_o), w_pop.data);
                    checkOutput("wen_cnt", 32'(xfer_cnt), w_pop.cnt);
                    checkOutput("wen_cycle", cyc, w_pop.cyc);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        rqt   = '0;
        adr   = '0;
        dat   = '0;
        full  = '0;
        #1;
        doReset();

        // Single request to destination 2
        applyStimulus(4'b0001, 8'h02, 16'h000A, 4'h0);
        checkOutput("single_gnt", 32'(gnt), 32'b0001);
        checkOutput("single_busy", 32'(busy), 1);
        applyStimulus(4'b0000, 8'h02, 16'h000A, 4'h0);
        checkOutput("single_wen", 32'(wen), 32'b0100);
        checkOutput("single_dat", 32'(dat_o), 32'hA);
        applyStimulus(4'b0000, 8'h00, 16'h0000, 4'h0);
        checkOutput("single_cnt", 32'(xfer_cnt), 1);
        checkOutput("single_idle", 32'(busy), 0);

        // Round-robin with every port requesting destination 0
        doReset();
        for (int c = 0; c < 15; c++) applyStimulus(4'b1111, 8'h00, 16'h4321, 4'h0);
        for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 8'h00, 16'h0000, 4'h0);

        // Port0 targets a full FIFO, so port1 wins first
        applyStimulus(4'b0011, 8'b0000_1001, 16'h0075, 4'b0010);
        checkOutput("mask_first", 32'(gnt), 32'b0010);
        for (int c = 0; c < 4; c++) applyStimulus(4'b0001, 8'b0000_1001, 16'h0075, 4'b0010);
        for (int c = 0; c < 6; c++) applyStimulus(4'b0001, 8'b0000_1001, 16'h0075, 4'b0000);
        for (int c = 0; c < 4; c++) applyStimulus(4'b0000, 8'h00, 16'h0000, 4'h0);

        // Stall in WRITE while destination 3 is full
        applyStimulus(4'b0100, 8'b0011_0000, 16'h0500, 4'h0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b0000, 8'b0011_0000, 16'h0000, 4'b1000);
            checkOutput("stall_wen", 32'(wen), 0);
            checkOutput("stall_busy", 32'(busy), 1);
            checkOutput("stall_dat", 32'(dat_o), 5);
        end
        applyStimulus(4'b0000, 8'h00, 16'h0000, 4'h0);
        checkOutput("stall_done", 32'(busy), 0);

        // Reset while stalled aborts the transfer; pointer returns to port 0
        applyStimulus(4'b0100, 8'b0011_0000, 16'h0900, 4'h0);
        for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 8'h00, 16'h0000, 4'b1000);
        doReset();
        applyStimulus(4'b1111, 8'b1110_0100, 16'h1234, 4'h0);
        checkOutput("post_rst_gnt", 32'(gnt), 32'b0001);
        for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 8'h00, 16'h0000, 4'h0);

        // 256 completions wrap the counter back to zero
        doReset();
        for (int c = 0; c < 800 && m_done < 256; c++) begin
            applyStimulus(4'b1111, 8'($urandom), 16'($urandom), 4'h0);
        end
        checkOutput("wrap_cnt", 32'(xfer_cnt), 0);

        // Random traffic: requests held until granted, FIFOs randomly full
        r_rqt = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!r_rqt[k] && $urandom_range(0, 2) == 0) begin
                    r_rqt[k] = 1'b1;
                    r_adr[k] = 2'($urandom_range(0, 3));
                    r_dat[k] = 4'($urandom_range(0, 15));
                end
                r_full[k] = ($urandom_range(0, 3) == 0);
            end
            applyStimulus(r_rqt, {r_adr[3], r_adr[2], r_adr[1], r_adr[0]},
                          {r_dat[3], r_dat[2], r_dat[1], r_dat[0]}, r_full);
            if (m_last_grant >= 0) r_rqt[m_last_grant] = 1'b0;
        end

        for (int c = 0; c < 10; c++) applyStimulus(4'b0000, 8'h00, 16'h0000, 4'h0);
        checkOutput("end_busy", 32'(busy), 0);
        checkOutput("end_gnt_pending", gnt_q.size(), 0);
        checkOutput("end_wr_pending", wr_q.size(), 0);
        checkOutput("end_cnt", 32'(xfer_cnt), m_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
